dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-master arbiter that shares the single DRAM data port between the RISCV core data interface (master 0) and a program/debug loader (master 1). It sits between both masters and the DRAM instance. It performs the 0x1001xxxx address decode that currently drives DRAM_CS, and returns read data one cycle after grant, tagged to the granted master. Out-of-range accesses are absorbed and flagged with an error pulse.

## Interface
- BASE_HI, 16'h1001: required value of ADDR[31:16] for a DRAM hit
- ADDR_W, 32: master address width; DRAM_ADDR carries ADDR[15:0]
- DATA_W, 32: data width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- M0_REQ, M1_REQ  in  1  access request, held with ADDR/WDATA/WR_EN stable until GNT
- M0_ADDR, M1_ADDR  in  ADDR_W  byte address
- M0_WDATA, M1_WDATA  in  DATA_W  write data
- M0_WR_EN, M1_WR_EN  in  2  DRAM write-size code; 2'b00 = read
- M1_LOCK  in  1  loader holds ownership across consecutive accesses
- M0_GNT, M1_GNT  out  1  combinational; access executes this cycle
- M0_RDATA, M1_RDATA  out  DATA_W  registered read data
- M0_RVALID, M1_RVALID  out  1  one-cycle pulse, read data valid
- M0_ERR, M1_ERR  out  1  one-cycle pulse, out-of-range access
- DRAM_ADDR  out  16  to DRAM ADDR
- DRAM_IN  out  DATA_W  to DRAM DATA_IN
- DRAM_WR_EN  out  2  to DRAM WR_EN
- DRAM_CS  out  1  to DRAM CS
- DRAM_OUT  in  DATA_W  from DRAM DATA_OUT

## Operation
- Registered state:
  - last-owner pointer LAST (0/1)
  - LOCKED flag
  - read-return pipeline: valid, tag, err
  - RDATA register
- Grant is combinational from REQ, LAST and LOCKED:
  - At most one GNT per cycle.
  - No GNT when neither REQ is high.
- Arbitration (with DRAM_ARB_RR_EN):
  - Both requesting: grant the master ≠ LAST.
  - One requesting: grant it.
- LOCKED=1: grant only M1. M0 waits even if M1_REQ is low.
- LOCKED update each edge:
  - Set when M1_GNT & M1_LOCK.
  - Clear when M1_LOCK=0.
- LAST updates to the granted master on every grant.
- DRAM mux: DRAM_ADDR/DRAM_IN/DRAM_WR_EN come from the granted master, else zero.
- Address decode:
  - Hit = granted ADDR[31:16]==BASE_HI.
  - DRAM_CS = GNT & hit.
  - Miss: DRAM_WR_EN forced 2'b00, DRAM_CS=0.
- Read return: a granted read (WR_EN==0) with hit captures DRAM_OUT into RDATA.
- Response outputs:
  - Mx_RVALID pulses the next cycle.
  - A miss pulses Mx_ERR the next cycle, RVALID stays 0, RDATA holds its previous value.
  - Writes with hit produce no response.
- Non-granted master's RDATA holds its previous value.

## Timing
- Reset values:
  - All GNT/RVALID/ERR = 0.
  - RDATA = 0.
  - LAST = 1, so M0 wins the first contention.
  - LOCKED = 0.
  - DRAM outputs = 0.
- GNT is combinational in cycle N. The master may change ADDR/WR_EN or drop REQ from cycle N+1.
- Write: committed by DRAM on the edge ending cycle N.
- Read/err latency: 1 cycle. RVALID/ERR are high in cycle N+1 only.
- Back-to-back:
  - A master holding REQ high gets consecutive cycles when the other master is idle.
  - Under contention (RR) grants alternate every cycle.
- Simultaneous M1_LOCK rise and M0 contention: arbitration first, lock applies from the next cycle.
- Async reset mid-access: outputs drop immediately, a pending RVALID/ERR is lost, and a write in progress is not guaranteed.

## Configuration
- DRAM_ARB_RR_EN defined: round-robin via LAST, as above.
- Undefined: fixed priority, M0 always wins. LAST is still tracked but unused, and M1 can starve. LOCK behaviour is unchanged.

## Structure
- Shared package dram_arb_pkg:
  - master-index constants M_CORE=0, M_LOADER=1
  - WR_EN read code 2'b00
  - default BASE_HI
- One sub-module, dram_arb_grant: combinational grant logic (REQ, LAST, LOCKED → GNT). The top holds the registers, the mux and the decode.

## Test plan
- Reset: RST=0 → all GNT/RVALID/ERR=0, DRAM_CS=0. Release, then M0 read 0x10010004 → M0_GNT in cycle 0, M0_RVALID with the DRAM word in cycle 1.
- Contention: M0 and M1 both read every cycle → with DRAM_ARB_RR_EN grants go M0,M1,M0,M1. Without it, M0 every cycle and M1 never.
- Write then read: M1 writes 0xDEADBEEF to 0x10010010 (WR_EN=2'b11), then M0 reads that address → M0_RDATA=0xDEADBEEF, one cycle after grant.
- Out of range: M0 reads 0x00400000 → DRAM_CS=0, M0_ERR pulses in cycle 1, RVALID=0, RDATA unchanged.
- Lock: M1 holds M1_LOCK for 3 accesses while M0_REQ is high → M1_GNT 3 times, M0 gets no GNT until the cycle after M1_LOCK falls.
- Async reset while an M0 read is pending → no RVALID after reset release, LAST=1.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-master DRAM arbiter: master indices,
// the DRAM read code and the default DRAM window base.
package dram_arb_pkg;

  typedef enum logic {
    M_CORE   = 1'b0,
    M_LOADER = 1'b1
  } master_e;

  localparam logic [1:0]  WR_EN_READ      = 2'b00;
  localparam logic [15:0] BASE_HI_DEFAULT = 16'h1001;

endpackage

// File: rtl/dram_arb_grant.sv
// Combinational grant selection for the DRAM arbiter.
// Build option: DRAM_ARB_RR_EN selects round-robin on contention; without it
// the core (master 0) always wins and the last-owner input is ignored.
module dram_arb_grant
  import dram_arb_pkg::*;
(
  input  logic    m0_req,
  input  logic    m1_req,
  input  master_e last,
  input  logic    locked,
  output logic    m0_gnt,
  output logic    m1_gnt
);

`ifndef DRAM_ARB_RR_EN
  // Fixed priority still receives the owner pointer so the port list is
  // identical in both builds.
  logic unused_last;
  assign unused_last = last;
`endif

  // Pick at most one master; a held lock reserves the port for the loader.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (locked) begin
      m1_gnt = m1_req;
    end else if (m0_req && m1_req) begin
`ifdef DRAM_ARB_RR_EN
      if (last == M_CORE) m1_gnt = 1'b1;
      else                m0_gnt = 1'b1;
`else
      m0_gnt = 1'b1;
`endif
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master DRAM port arbiter: core data port (master 0) and program/debug
// loader (master 1). Holds the owner/lock state, muxes the granted access onto
// the DRAM port, decodes the DRAM window and returns tagged read data or an
// out-of-range error one cycle after grant.
// Build option: DRAM_ARB_RR_EN enables round-robin arbitration (default is
// fixed priority to master 0).
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter logic [15:0] BASE_HI = BASE_HI_DEFAULT,
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_wr_en,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_wr_en,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              m0_err,
  output logic              m1_err,
  output logic [15:0]       dram_addr,
  output logic [DATA_W-1:0] dram_in,
  output logic [1:0]        dram_wr_en,
  output logic              dram_cs,
  input  logic [DATA_W-1:0] dram_out
);

  master_e           last;
  logic              locked;
  logic              m0_gnt_raw;
  logic              m1_gnt_raw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_wr_en;
  logic              any_gnt;
  logic              hit;
  logic              rd_hit;
  logic              miss;

  dram_arb_grant u_grant (
    .m0_req (m0_req),
    .m1_req (m1_req),
    .last   (last),
    .locked (locked),
    .m0_gnt (m0_gnt_raw),
    .m1_gnt (m1_gnt_raw)
  );

  // Grants are combinational, so reset has to mask them directly for the
  // port to go quiet the moment reset asserts.
  assign m0_gnt  = m0_gnt_raw & rst_n;
  assign m1_gnt  = m1_gnt_raw & rst_n;
  assign any_gnt = m0_gnt | m1_gnt;

  // Route the granted master's access; everything reads zero when idle.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr_en = WR_EN_READ;
    if (m0_gnt) begin
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_wr_en = m0_wr_en;
    end else if (m1_gnt) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wr_en = m1_wr_en;
    end
  end

  assign hit    = any_gnt && (sel_addr[ADDR_W-1 -: 16] == BASE_HI);
  assign rd_hit = hit && (sel_wr_en == WR_EN_READ);
  assign miss   = any_gnt && !hit;

  // A miss never reaches the DRAM: chip select and write strobe stay low.
  assign dram_addr  = sel_addr[15:0];
  assign dram_in    = sel_wdata;
  assign dram_wr_en = hit ? sel_wr_en : WR_EN_READ;
  assign dram_cs    = hit;

  // Ownership state: last granted master and the loader lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= M_LOADER;
      locked <= 1'b0;
    end else begin
      if (m0_gnt)      last <= M_CORE;
      else if (m1_gnt) last <= M_LOADER;

      if (!m1_lock)    locked <= 1'b0;
      else if (m1_gnt) locked <= 1'b1;
    end
  end

  // One-cycle response pulses and per-master read data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & rd_hit;
      m1_rvalid <= m1_gnt & rd_hit;
      m0_err    <= m0_gnt & miss;
      m1_err    <= m1_gnt & miss;
      if (m0_gnt && rd_hit) m0_rdata <= dram_out;
      if (m1_gnt && rd_hit) m1_rdata <= dram_out;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed testbench for dram_arbiter with a small word-addressed DRAM model.
// Unwritten DRAM words read back as {16'hC0DE, low address}.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]  m0_wr_en, m1_wr_en;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [15:0] dram_addr;
  logic [31:0] dram_in, dram_out;
  logic [1:0]  dram_wr_en;
  logic        dram_cs;

  int checks = 0;
  int errors = 0;

`ifdef DRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  dram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr_en(m0_wr_en),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr_en(m1_wr_en),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_err(m0_err), .m1_err(m1_err),
    .dram_addr(dram_addr), .dram_in(dram_in), .dram_wr_en(dram_wr_en),
    .dram_cs(dram_cs), .dram_out(dram_out)
  );

  logic [31:0] mem [0:63];
  logic [63:0] wr_seen = '0;

  assign dram_out = wr_seen[dram_addr[7:2]] ? mem[dram_addr[7:2]]
                                            : {16'hC0DE, 8'h00, dram_addr[7:2], 2'b00};

  always @(posedge clk) begin
    if (dram_cs && dram_wr_en != 2'b00) begin
      mem[dram_addr[7:2]]     <= dram_in;
      wr_seen[dram_addr[7:2]] <= 1'b1;
    end
  end

  task automatic idle();
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_wr_en = 2'b00;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_wr_en = 2'b00; m1_lock = 0;
  endtask

  // Start of a new cycle: just after the rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m0_req = 1; m0_addr = 32'h1001_0004;
    #2;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); end
    checks++; if (dram_cs !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", dram_cs); end
    checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", m0_rdata); end
    checks++; if ({dram_addr, dram_wr_en} !== 18'h0) begin errors++; $display("FAIL rst_dram: got %h want 0", {dram_addr, dram_wr_en}); end
    m0_req = 0;
    @(posedge clk); @(negedge clk); rst_n = 1;
    next_cycle();
    // cycle 0: M0 read
    m0_req = 1; m0_addr = 32'h1001_0004; m0_wr_en = 2'b00;
    #3;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", m0_gnt); end
    checks++; if (dram_cs !== 1'b1 || dram_addr !== 16'h0004) begin errors++; $display("FAIL rd_dram: got cs=%b addr=%h want cs=1 addr=0004", dram_cs, dram_addr); end
    next_cycle();
    idle();
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'hC0DE_0004) begin errors++; $display("FAIL rd_rdata: got %h want C0DE0004", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL rd_others: got m1_rvalid=%b m0_err=%b want 0 0", m1_rvalid, m0_err); end
    next_cycle();
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse_end: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_contention();
    bit exp_m0 [4];
    do_reset();
    for (int k = 0; k < 4; k++) exp_m0[k] = RR ? (k % 2 == 0) : 1'b1;
    m0_req = 1; m0_addr = 32'h1001_0008;
    m1_req = 1; m1_addr = 32'h1001_000C;
    for (int k = 0; k < 4; k++) begin
      #3;
      checks++; if (m0_gnt !== exp_m0[k] || m1_gnt !== !exp_m0[k]) begin errors++; $display("FAIL cont_gnt[%0d]: got m0=%b m1=%b want m0=%b m1=%b", k, m0_gnt, m1_gnt, exp_m0[k], !exp_m0[k]); end
      if (k > 0) begin
        checks++; if (m0_rvalid !== exp_m0[k-1] || m1_rvalid !== !exp_m0[k-1]) begin errors++; $display("FAIL cont_rvalid[%0d]: got m0=%b m1=%b want m0=%b m1=%b", k, m0_rvalid, m1_rvalid, exp_m0[k-1], !exp_m0[k-1]); end
      end
      next_cycle();
    end
    idle();
    checks++; if (m0_rdata !== 32'hC0DE_0008) begin errors++; $display("FAIL cont_m0_rdata: got %h want C0DE0008", m0_rdata); end
    checks++; if (m1_rdata !== (RR ? 32'hC0DE_000C : 32'h0)) begin errors++; $display("FAIL cont_m1_rdata: got %h want %h", m1_rdata, RR ? 32'hC0DE_000C : 32'h0); end
    next_cycle();
  endtask

  task automatic test_write_read();
    m1_req = 1; m1_addr = 32'h1001_0010; m1_wdata = 32'hDEAD_BEEF; m1_wr_en = 2'b11;
    #3;
    checks++; if (m1_gnt !== 1'b1 || dram_cs !== 1'b1) begin errors++; $display("FAIL wr_gnt_cs: got gnt=%b cs=%b want 1 1", m1_gnt, dram_cs); end
    checks++; if (dram_wr_en !== 2'b11 || dram_addr !== 16'h0010 || dram_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_port: got we=%b addr=%h in=%h want 11 0010 DEADBEEF", dram_wr_en, dram_addr, dram_in); end
    next_cycle();
    idle();
    m0_req = 1; m0_addr = 32'h1001_0010;
    checks++; if (m1_rvalid !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("FAIL wr_no_resp: got rvalid=%b err=%b want 0 0", m1_rvalid, m1_err); end
    #3;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL wrrd_gnt: got %b want 1", m0_gnt); end
    next_cycle();
    idle();
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wrrd_data: got rvalid=%b rdata=%h want 1 DEADBEEF", m0_rvalid, m0_rdata); end
    next_cycle();
  endtask

  task automatic test_out_of_range();
    m0_req = 1; m0_addr = 32'h0040_0000; m0_wr_en = 2'b00;
    #3;
    checks++; if (m0_gnt !== 1'b1 || dram_cs !== 1'b0 || dram_wr_en !== 2'b00) begin errors++; $display("FAIL oor_port: got gnt=%b cs=%b we=%b want 1 0 00", m0_gnt, dram_cs, dram_wr_en); end
    next_cycle();
    idle();
    checks++; if (m0_err !== 1'b1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL oor_resp: got err=%b rvalid=%b want 1 0", m0_err, m0_rvalid); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_rdata: got %h want DEADBEEF", m0_rdata); end
    next_cycle();
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL oor_pulse_end: got %b want 0", m0_err); end
    // an out-of-range write must not strobe the DRAM either
    m1_req = 1; m1_addr = 32'h1002_0010; m1_wdata = 32'h1234_5678; m1_wr_en = 2'b11;
    #3;
    checks++; if (dram_cs !== 1'b0 || dram_wr_en !== 2'b00) begin errors++; $display("FAIL oor_wr_port: got cs=%b we=%b want 0 00", dram_cs, dram_wr_en); end
    next_cycle();
    idle();
    checks++; if (m1_err !== 1'b1 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL oor_wr_resp: got err=%b rvalid=%b want 1 0", m1_err, m1_rvalid); end
    next_cycle();
  endtask

  task automatic test_lock();
    int m1_cnt = 0;
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h1001_0020;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin m0_req = 1; m0_addr = 32'h1001_0004; end
      #3;
      if (m1_gnt === 1'b1) m1_cnt++;
      checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL lock_m0_blocked[%0d]: got %b want 0", k, m0_gnt); end
      next_cycle();
    end
    checks++; if (m1_cnt != 3) begin errors++; $display("FAIL lock_m1_count: got %0d want 3", m1_cnt); end
    m1_req = 0; m1_lock = 0;
    #3;
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL lock_release_cycle: got m0=%b m1=%b want 0 0", m0_gnt, m1_gnt); end
    next_cycle();
    #3;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL lock_m0_after: got %b want 1", m0_gnt); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    m0_req = 1; m0_addr = 32'h1001_0004;
    next_cycle();
    m0_addr = 32'h1001_0008;
    #3;
    rst_n = 0;
    #1;
    checks++; if (m0_gnt !== 1'b0 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL arst_drop: got gnt=%b rvalid=%b want 0 0", m0_gnt, m0_rvalid); end
    idle();
    @(posedge clk);
    @(negedge clk); rst_n = 1;
    next_cycle();
    checks++; if (m0_rvalid !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL arst_lost: got rvalid=%b err=%b want 0 0", m0_rvalid, m0_err); end
    m0_req = 1; m0_addr = 32'h1001_0004;
    m1_req = 1; m1_addr = 32'h1001_000C;
    #3;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL arst_last: got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_contention();
    test_write_read();
    test_out_of_range();
    test_lock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
